// File: rtl/dbi_encoder_pipe.sv
// dbi_encoder_pipe: two-stage pipelined multi-lane DBI encoder (bypass/DC/AC) with saturating inversion statistic
module dbi_encoder_pipe #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic [1:0]              in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_data,
   output logic [LANES-1:0]        out_dbi,
   input  logic                    stat_clr,
   output logic [CNT_W-1:0]        inv_count
);
   localparam int W = LANES * LANE_W;
   localparam int SW = CNT_W + 5;
   localparam logic [4:0] HALF = 5'(LANE_W / 2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [4:0] pop(input logic [15:0] v);
      pop = '0;
      for (int i = 0; i < 16; i++) pop = pop + 5'(v[i]);
   endfunction

   logic          s1_valid;
   logic [W-1:0]  s1_data;
   logic [1:0]    s1_mode;
   logic [W-1:0]  hist_data;
   logic [W-1:0]  enc_data;
   logic [LANES-1:0] inv;
   logic [LANE_W-1:0] lane, prev;
   logic          s2_load, in_fire, out_fire;
   logic [4:0]    dbi_pop;
   logic [SW-1:0] cnt_sum;

   assign in_ready = ~s1_valid | ~out_valid | out_ready;
   assign in_fire  = in_valid & in_ready;
   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign out_fire = out_valid & out_ready;
   assign dbi_pop  = pop(16'(out_dbi));
   assign cnt_sum  = SW'(inv_count) + SW'(dbi_pop);

   // Per-lane invert decision; DC inverts when zeros exceed half (ones below half), ties never invert
   always_comb begin
      inv = '0;
      enc_data = '0;
      lane = '0;
      prev = '0;
      for (int k = 0; k < LANES; k++) begin
         lane = s1_data[k*LANE_W +: LANE_W];
         prev = hist_data[k*LANE_W +: LANE_W];
         inv[k] = s1_mode == 2'd1 ? pop(16'(lane)) < HALF :
                  s1_mode == 2'd2 ? pop(16'(lane ^ prev)) > HALF : 1'b0;
         enc_data[k*LANE_W +: LANE_W] = inv[k] ? ~lane : lane;
      end
   end

   // Stage 1: capture raw word and its mode on input handshake
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_mode  <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_data  <= in_data;
         s1_mode  <= in_mode;
      end else if (s2_load) s1_valid <= 1'b0;

   // Stage 2: output register and transmit history; out_dbi doubles as the history DBI flags
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_dbi   <= '0;
         hist_data <= '1;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= enc_data;
         out_dbi   <= inv;
         hist_data <= enc_data;
      end else if (out_fire) out_valid <= 1'b0;

   // Saturating count of inverted lanes delivered; clear wins over increment
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) inv_count <= '0;
      else if (stat_clr) inv_count <= '0;
      else if (out_fire) inv_count <= cnt_sum > SW'(CNT_MAX) ? CNT_MAX : cnt_sum[CNT_W-1:0];
endmodule

// File: tb/tb_dbi_encoder_pipe.sv
// tb_dbi_encoder_pipe: directed self-checking bench for dbi_encoder_pipe (4 lanes x 8 bits, 4-bit statistic)
module tb_dbi_encoder_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  in_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [3:0]  out_dbi;
   logic        stat_clr = 1'b0;
   logic [3:0]  inv_count;
   int tests = 0;
   int fails = 0;

   dbi_encoder_pipe #(.LANES(4), .LANE_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_dbi(out_dbi),
      .stat_clr(stat_clr), .inv_count(inv_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // single word through an idle pipe with out_ready high; checks the encoded output
   task automatic send1(input string tag, input logic [31:0] d, input logic [1:0] m,
                        input logic [31:0] ed, input logic [3:0] eb);
      in_valid = 1'b1;
      in_data = d;
      in_mode = m;
      tick;
      in_valid = 1'b0;
      chk({tag, "_lat"}, 32'(out_valid), 32'd0);
      tick;
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, out_data, ed);
      chk({tag, "_dbi"}, 32'(out_dbi), 32'(eb));
      tick;
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_dbi", 32'(out_dbi), 32'd0);
      chk("rst_inv_count", 32'(inv_count), 32'd0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      // DC: lane0 all zeros inverts
      send1("dc1", 32'hFFFF_FF00, 2'd1, 32'hFFFF_FFFF, 4'b0001);
      chk("dc1_cnt", 32'(inv_count), 32'd1);
      chk("dc1_drain", 32'(out_valid), 32'd0);
      // DC tie never inverts
      send1("dc_tie", 32'h0F0F_0F0F, 2'd1, 32'h0F0F_0F0F, 4'h0);
      // AC after reset, back-to-back
      rst_n = 1'b0;
      #2;
      chk("ac_rst_cnt", 32'(inv_count), 32'd0);
      tick;
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_mode = 2'd2;
      in_data = 32'h0000_0000;
      tick;
      in_data = 32'h0101_0101;
      tick;
      in_valid = 1'b0;
      chk("ac1_data", out_data, 32'hFFFF_FFFF);
      chk("ac1_dbi", 32'(out_dbi), 32'hF);
      tick;
      chk("ac2_data", out_data, 32'hFEFE_FEFE);
      chk("ac2_dbi", 32'(out_dbi), 32'hF);
      chk("ac2_cnt_mid", 32'(inv_count), 32'd4);
      tick;
      chk("ac2_cnt", 32'(inv_count), 32'd8);
      chk("ac2_drain", 32'(out_valid), 32'd0);
      // Reserved mode is bypass and still updates history
      send1("byp", 32'h0000_0000, 2'd3, 32'h0000_0000, 4'h0);
      send1("ac_after_byp", 32'hFFFF_FFFF, 2'd2, 32'h0000_0000, 4'hF);
      chk("cnt12", 32'(inv_count), 32'd12);
      // Saturation at 15
      send1("sat1", 32'hFFFF_FFFF, 2'd2, 32'h0000_0000, 4'hF);
      chk("sat1_cnt", 32'(inv_count), 32'd15);
      send1("sat2", 32'hFFFF_FFFF, 2'd2, 32'h0000_0000, 4'hF);
      chk("sat2_cnt", 32'(inv_count), 32'd15);
      // stat_clr beats a same-cycle handshake increment
      in_valid = 1'b1;
      in_data = 32'hFFFF_FFFF;
      tick;
      in_valid = 1'b0;
      tick;
      chk("clr_dbi", 32'(out_dbi), 32'hF);
      stat_clr = 1'b1;
      tick;
      stat_clr = 1'b0;
      chk("clr_cnt", 32'(inv_count), 32'd0);
      // Backpressure: three bypass words, out_ready low for five cycles
      out_ready = 1'b0;
      in_mode = 2'd0;
      in_valid = 1'b1;
      in_data = 32'h1111_1111;
      chk("bp_rdy0", 32'(in_ready), 32'd1);
      tick;
      in_data = 32'h2222_2222;
      chk("bp_rdy1", 32'(in_ready), 32'd1);
      tick;
      in_data = 32'h3333_3333;
      chk("bp_rdy2", 32'(in_ready), 32'd0);
      chk("bp_hold0", out_data, 32'h1111_1111);
      tick;
      tick;
      tick;
      chk("bp_rdy5", 32'(in_ready), 32'd0);
      chk("bp_hold3", out_data, 32'h1111_1111);
      chk("bp_vld3", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_rdy_resume", 32'(in_ready), 32'd1);
      tick;
      in_valid = 1'b0;
      chk("bp_w2", out_data, 32'h2222_2222);
      tick;
      chk("bp_w3", out_data, 32'h3333_3333);
      chk("bp_w3_vld", 32'(out_valid), 32'd1);
      tick;
      chk("bp_drain", 32'(out_valid), 32'd0);
      chk("bp_cnt", 32'(inv_count), 32'd0);
      // Reset mid-stream drops the held word and restores idle-high history
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_mode = 2'd2;
      in_data = 32'h5555_5555;
      tick;
      tick;
      in_valid = 1'b0;
      chk("mid_vld", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      tick;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick;
      tick;
      chk("mid_no_stale", 32'(out_valid), 32'd0);
      send1("mid_hist", 32'h0000_0000, 2'd2, 32'hFFFF_FFFF, 4'hF);
      chk("mid_cnt", 32'(inv_count), 32'd4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dbi_encoder_pipe.md
Name: dbi_encoder_pipe

Overview:
Parametrised, pipelined Data Bus Inversion encoder for a multi-lane bus. It generalises the team's fixed 9-input majority/AOI decision cell. Per lane, it decides whether to invert using either DC mode (count of zeros) or AC mode (transitions against the last transmitted word). Bypass mode passes data through unchanged. The block sits between the write-data datapath and the PHY serializer, uses valid/ready on both sides, and keeps a saturating inversion statistic.

Parameters:
LANES, 4, number of independent byte lanes, each with its own DBI bit; range 1..16.
LANE_W, 8, data bits per lane; even, range 4..16.
CNT_W, 16, width of the inversion statistic counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word valid.
in_ready  output  1  block can accept a word this cycle.
in_data  input  LANES*LANE_W  raw data; lane k occupies bits [k*LANE_W +: LANE_W].
in_mode  input  2  per-word mode: 0 = bypass, 1 = DC, 2 = AC, 3 = reserved (treated as bypass).
out_valid  output  1  encoded word valid.
out_ready  input  1  downstream accepts.
out_data  output  LANES*LANE_W  encoded data (inverted lanes complemented).
out_dbi  output  LANES  per-lane inversion flag (1 = lane inverted).
stat_clr  input  1  synchronous clear of inv_count.
inv_count  output  CNT_W  saturating count of inverted lanes on output handshakes.

Behaviour:
- Reset (async assert, sync release) forces:
  - out_valid = 0, out_data = 0, out_dbi = 0, inv_count = 0, s1_valid = 0.
  - History register hist_data = all ones (idle bus high); hist_dbi = 0.
- Pipeline has two register stages:
  - S1 captures in_data and in_mode on an in handshake (in_valid & in_ready).
  - S2 is the output register.
  - Latency from input handshake to out_valid is 2 cycles when not stalled.
  - Throughput is 1 word/cycle.
- Advance rules:
  - s2_load = s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | ~out_valid | out_ready.
  - out_valid clears on (out_valid & out_ready) when S2 is not reloaded the same cycle.
- Decision logic is combinational between S1 and S2, per lane k:
  - DC: z = number of 0 bits in the lane; invert iff z > LANE_W/2.
  - AC: t = popcount(lane XOR hist_data lane); invert iff t > LANE_W/2.
  - Ties (exactly LANE_W/2) never invert.
  - Bypass/reserved: invert = 0.
- Output registers on s2_load:
  - out_data lane = invert ? ~lane : lane.
  - out_dbi[k] = invert.
- History update: hist_data <= encoded word and hist_dbi <= out_dbi, both on every s2_load in all modes. Back-to-back AC words therefore compare against the immediately preceding encoded word, with no bubble.
- Held words: while out_valid & ~out_ready, out_data and out_dbi are held stable and S1 is held. in_data changes are ignored until the next handshake.
- Mode is sampled per word; switching modes mid-stream is legal and takes effect on that word only.
- inv_count adds popcount(out_dbi) on each output handshake and saturates at 2^CNT_W-1. stat_clr has priority over an increment in the same cycle.
- Reset mid-operation drops any in-flight words, with no partial output, and reinitialises the history.

Test Plan:
1. DC, lane0 = 0x00, other lanes 0xFF, out_ready = 1 -> two cycles later out_data lane0 = 0xFF, out_dbi = 4'b0001, inv_count = 1.
2. DC tie: all lanes 0x0F -> out_data = 0x0F0F0F0F, out_dbi = 0.
3. AC after reset: word 0x00000000, then 0x01010101 back-to-back -> first output 0xFFFFFFFF with dbi 4'hF. Second is compared against 0xFF (7 transitions), giving 0xFEFEFEFE with dbi 4'hF; inv_count = 8.
4. Backpressure: hold out_ready = 0 for 5 cycles while streaming 3 words -> in_ready drops after 2 accepted, output is held stable, and in-order delivery resumes with no loss or duplication when out_ready rises.
5. Bypass, in_mode = 3, data 0x00000000 -> output unchanged with dbi 0. A following AC word 0xFFFFFFFF compares against 0x00000000 and is inverted to 0x00000000 with dbi 4'hF.
6. CNT_W = 4: stream all-inverting words until saturation -> inv_count sticks at 15. Asserting stat_clr with a handshake in the same cycle -> 0. Asserting rst_n low mid-stream -> out_valid = 0 immediately.
